// File: rtl/alu_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the ALU control sequencer.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_MULT = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_DIV  = 6'b011010;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_MULT = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_DIV  = 4'b1000;
    localparam logic [3:0] OP_IMM  = 4'b1010;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    typedef enum logic [1:0] {ST_IDLE, ST_MULTI, ST_HOLD} state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct decode. ALU_CTRL_ILLEGAL_TRAP_EN maps unknown
// R-type funct codes to the trap opcode instead of add.
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] opcode,
    output logic       multi,
    output logic       unknown
);

    always_comb begin
        unknown = 1'b0;
        opcode  = OP_ADD;
        case (alu_op)
            ALUOP_ADD: opcode = OP_ADD;
            ALUOP_SUB: opcode = OP_SUB;
            ALUOP_IMM: opcode = OP_IMM;
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD:   opcode = OP_ADD;
                    F_SUB:   opcode = OP_SUB;
                    F_MULT:  opcode = OP_MULT;
                    F_AND:   opcode = OP_AND;
                    F_OR:    opcode = OP_OR;
                    F_SLT:   opcode = OP_SLT;
                    F_XOR:   opcode = OP_XOR;
                    F_DIV:   opcode = OP_DIV;
                    default: begin
                        unknown = 1'b1;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                        opcode  = OP_ILL;
`else
                        opcode  = OP_ADD;
`endif
                    end
                endcase
            end
        endcase
        multi = is_multicycle(opcode);
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes requests, holds multi-cycle ops for MC_LAT
// cycles, presents a valid/ready result. ALU_CTRL_ILLEGAL_TRAP_EN adds sticky illegal.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MC_LAT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] alu_opcode,
    output logic       busy,
    output logic       illegal
);

    localparam int CNT_W = $clog2(MC_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic [3:0]       dec_opcode;
    logic             dec_multi;
    logic             dec_unknown;

    alu_ctrl_dec u_dec (
        .alu_op  (alu_op),
        .funct   (funct),
        .opcode  (dec_opcode),
        .multi   (dec_multi),
        .unknown (dec_unknown)
    );

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            alu_opcode <= OP_AND;
        end else begin
            state <= state_nx;
            if (flush)
                cnt <= '0;
            else if (accept && dec_multi)
                cnt <= CNT_LOAD;
            else if (state == ST_MULTI && cnt != '0)
                cnt <= cnt - 1'b1;
            if (accept)
                alu_opcode <= dec_opcode;
        end
    end

    // In HOLD with out_ready, in_ready is high, so no accept means no request.
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept) state_nx = dec_multi ? ST_MULTI : ST_HOLD;
                ST_MULTI: if (cnt == '0) state_nx = ST_HOLD;
                ST_HOLD: begin
                    if (out_ready)
                        state_nx = accept ? (dec_multi ? ST_MULTI : ST_HOLD) : ST_IDLE;
                end
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state == ST_MULTI);
        out_valid = (state == ST_HOLD);
        in_ready  = !flush && ((state == ST_IDLE) || (state == ST_HOLD && out_ready));
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            illegal <= 1'b0;
        else if (flush)
            illegal <= 1'b0;
        else if (accept && dec_unknown)
            illegal <= 1'b1;
    end
`else
    logic unused_dec_unknown;
    assign unused_dec_unknown = dec_unknown;
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed + random bench for alu_ctrl_seq against a transaction-level model.
module tb_alu_ctrl_seq;

    localparam int MC_LAT = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0] alu_op = 2'b00;
    logic [5:0] funct = 6'b000000;
    logic       in_ready, out_valid, busy, illegal;
    logic [3:0] alu_opcode;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    // model: cycles of busy left, result presented, result code, sticky flag
    int       m_busy_left = 0;
    bit       m_present = 1'b0;
    bit [3:0] m_op = 4'h0;
    bit       m_ill = 1'b0;

    logic [5:0] ftab [8] = '{6'b100000, 6'b100010, 6'b100011, 6'b100100,
                             6'b100101, 6'b101010, 6'b100110, 6'b011010};
    logic [3:0] otab [8] = '{4'b0010, 4'b0110, 4'b0100, 4'b0000,
                             4'b0001, 4'b0111, 4'b0011, 4'b1000};

    alu_ctrl_seq #(.MC_LAT(MC_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .alu_op(alu_op), .funct(funct), .out_valid(out_valid),
        .out_ready(out_ready), .alu_opcode(alu_opcode), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic ref_decode(input logic [1:0] op, input logic [5:0] fn,
                              output bit [3:0] o, output bit unk);
        unk = 1'b0;
        if (op == 2'b00) o = 4'b0010;
        else if (op == 2'b01) o = 4'b0110;
        else if (op == 2'b11) o = 4'b1010;
        else begin
            unk = 1'b1;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            o = 4'b1111;
`else
            o = 4'b0010;
`endif
            for (int i = 0; i < 8; i++)
                if (ftab[i] == fn) begin o = otab[i]; unk = 1'b0; end
        end
    endtask

    // One cycle: drive at negedge, compare against model, advance model at posedge.
    task automatic cyc(input bit rn, input bit fl, input bit iv, input logic [1:0] op,
                       input logic [5:0] fn, input bit ordy);
        bit exp_rdy, acc, unk;
        bit [3:0] o;
        @(negedge clk);
        reset_n = rn; flush = fl; in_valid = iv; alu_op = op; funct = fn; out_ready = ordy;
        #1;
        exp_rdy = !fl && (m_busy_left == 0) && (!m_present || ordy);
        if (checking) begin
            chk("in_ready", {3'b0, in_ready}, {3'b0, exp_rdy});
            chk("out_valid", {3'b0, out_valid}, {3'b0, m_present});
            chk("busy", {3'b0, busy}, {3'b0, m_busy_left > 0});
            chk("alu_opcode", alu_opcode, m_op);
            chk("illegal", {3'b0, illegal}, {3'b0, m_ill});
        end
        acc = iv && exp_rdy;
        ref_decode(op, fn, o, unk);
        if (!rn) begin
            m_busy_left = 0; m_present = 0; m_op = 4'h0; m_ill = 0;
        end else if (fl) begin
            m_busy_left = 0; m_present = 0; m_ill = 0;
        end else if (acc) begin
            m_op = o;
            if (o == 4'b0100 || o == 4'b1000) begin
                m_busy_left = MC_LAT - 1; m_present = 0;
            end else begin
                m_busy_left = 0; m_present = 1;
            end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            if (unk) m_ill = 1;
`endif
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_present = 1;
        end else if (m_present && ordy) begin
            m_present = 0;
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 2'b00, 6'b0, ordy);
    endtask

    initial begin
        // reset; outputs are X until the first reset edge
        cyc(0, 1, 1, 2'b10, 6'b100011, 1);
        checking = 1'b1;
        cyc(0, 0, 1, 2'b10, 6'b100011, 1);
        after_edge();
        chk("reset_opcode", alu_opcode, 4'b0000);
        chk("reset_valid", {3'b0, out_valid}, 4'h0);
        idle(1, 1);

        // single-cycle add, latency 1, never busy
        cyc(1, 0, 1, 2'b10, 6'b100000, 1);
        after_edge();
        chk("add_valid", {3'b0, out_valid}, 4'h1);
        chk("add_opcode", alu_opcode, 4'b0010);
        chk("add_busy", {3'b0, busy}, 4'h0);
        idle(2, 1);

        // mult: busy cycles 1..MC_LAT-1, valid at MC_LAT
        cyc(1, 0, 1, 2'b10, 6'b100011, 1);
        for (int k = 1; k < MC_LAT; k++) begin
            after_edge();
            chk("mult_busy", {3'b0, busy}, 4'h1);
            chk("mult_rdy", {3'b0, in_ready}, 4'h0);
            cyc(1, 0, 1, 2'b10, 6'b100000, 1);
        end
        after_edge();
        chk("mult_valid", {3'b0, out_valid}, 4'h1);
        chk("mult_opcode", alu_opcode, 4'b0100);
        idle(2, 1);

        // sub held 3 cycles with out_ready low, then add back-to-back
        cyc(1, 0, 1, 2'b01, 6'b0, 1);
        idle(3, 0);
        after_edge();
        chk("hold_opcode", alu_opcode, 4'b0110);
        chk("hold_valid", {3'b0, out_valid}, 4'h1);
        cyc(1, 0, 1, 2'b00, 6'b0, 1);
        after_edge();
        chk("b2b_opcode", alu_opcode, 4'b0010);
        chk("b2b_valid", {3'b0, out_valid}, 4'h1);
        idle(2, 1);

        // div flushed at cycle 2: no out_valid
        cyc(1, 0, 1, 2'b10, 6'b011010, 1);
        idle(1, 1);
        cyc(1, 1, 1, 2'b10, 6'b100000, 1);
        for (int k = 0; k < MC_LAT; k++) begin
            after_edge();
            chk("flush_valid", {3'b0, out_valid}, 4'h0);
            chk("flush_busy", {3'b0, busy}, 4'h0);
            cyc(1, 0, 0, 2'b00, 6'b0, 1);
        end

        // reset mid-MULTI
        cyc(1, 0, 1, 2'b10, 6'b100011, 1);
        idle(1, 1);
        cyc(0, 1, 1, 2'b10, 6'b100000, 1);
        after_edge();
        chk("rst_mid_busy", {3'b0, busy}, 4'h0);
        chk("rst_mid_opcode", alu_opcode, 4'b0000);
        idle(2, 1);

        // unknown funct
        cyc(1, 0, 1, 2'b10, 6'b111111, 1);
        after_edge();
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        chk("ill_opcode", alu_opcode, 4'b1111);
        chk("ill_flag", {3'b0, illegal}, 4'h1);
`else
        chk("ill_opcode", alu_opcode, 4'b0010);
        chk("ill_flag", {3'b0, illegal}, 4'h0);
`endif
        idle(3, 1);
        cyc(1, 1, 0, 2'b00, 6'b0, 1);
        after_edge();
        chk("ill_cleared", {3'b0, illegal}, 4'h0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit rn, fl, iv, ordy;
            logic [1:0] op;
            logic [5:0] fn;
            rn   = ($urandom_range(0, 63) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            iv   = $urandom_range(0, 1) == 1;
            ordy = ($urandom_range(0, 3) != 0);
            op   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) fn = ftab[$urandom_range(0, 7)];
            else fn = 6'($urandom);
            cyc(rn, fl, iv, op, fn, ordy);
        end
        idle(2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter MC_LAT, default 4, range 2..16: cycles from accept to out_valid for a multi-cycle op.
REQ-002 SHALL have derived localparam CNT_W = clog2(MC_LAT), not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous pipeline flush.
REQ-006 in_valid  input  1  decode request present.
REQ-007 in_ready  output  1  block accepts the request this cycle.
REQ-008 alu_op  input  2  main-control ALUOp.
REQ-009 funct  input  6  R-type function field.
REQ-010 out_valid  output  1  alu_opcode valid for execute stage.
REQ-011 out_ready  input  1  execute stage consumes the result.
REQ-012 alu_opcode  output  4  registered ALU operation code.
REQ-013 busy  output  1  multi-cycle op in progress; upstream stall.
REQ-014 illegal  output  1  unrecognised funct seen (see Configuration).

Function
REQ-015 Decode SHALL be: ALUOp 00->0010; 01->0110; 11->1010; 10 by funct: 100000->0010, 100010->0110, 100011->0100, 100100->0000, 100101->0001, 101010->0111, 100110->0011, 011010->1000.
REQ-016 Multi-cycle ops SHALL be 0100 (mult) and 1000 (div); all others single-cycle.
REQ-017 States SHALL be IDLE, MULTI, HOLD; accept = in_valid & in_ready.
REQ-018 in_ready SHALL equal !flush & (state==IDLE | (state==HOLD & out_ready)).
REQ-019 On accept of single-cycle op: alu_opcode registered, state->HOLD, out_valid=1 next cycle (latency 1).
REQ-020 On accept of multi-cycle op: alu_opcode registered, counter loaded MC_LAT-2, state->MULTI; counter decrements in MULTI; at 0 state->HOLD; out_valid first high MC_LAT cycles after accept.
REQ-021 busy SHALL be 1 exactly while state==MULTI; out_valid SHALL be 1 exactly while state==HOLD.
REQ-022 In HOLD: out_ready & accept -> new op (back-to-back, no bubble); out_ready & !in_valid -> IDLE; !out_ready -> hold alu_opcode stable.
REQ-023 alu_opcode SHALL change only on accept; otherwise keeps last value.
REQ-024 flush SHALL force IDLE, clear counter, drop pending op, and block accept that cycle; alu_opcode keeps value; flush during MULTI aborts with no out_valid.

Reset
REQ-025 reset_n low at a clock edge SHALL force state IDLE, counter 0, alu_opcode 0000, out_valid 0, busy 0, illegal 0; reset overrides flush and in_valid, including mid-MULTI.

Configuration
REQ-026 Macro ALU_CTRL_ILLEGAL_TRAP_EN defined: unmatched funct with ALUOp 10 decodes to 1111, single-cycle, sets illegal sticky until flush or reset.
REQ-027 Macro undefined: unmatched funct decodes to 0010, illegal tied 0.

Structure
REQ-028 Package alu_ctrl_pkg SHALL hold ALUOp, funct and opcode constants, state enum, and is_multicycle function.
REQ-029 Combinational decode SHALL be sub-module alu_ctrl_dec (alu_op, funct -> opcode, multi, unknown); sequencing in alu_ctrl_seq.

Verification
REQ-030 ALUOp 10, funct 100000, out_ready=1 -> out_valid next cycle, alu_opcode 0010, busy never high.
REQ-031 MC_LAT=4, funct 100011 at cycle 0 -> busy cycles 1-3, out_valid cycle 4, alu_opcode 0100, in_ready 0 cycles 1-3.
REQ-032 out_ready=0 for 3 cycles in HOLD with sub (0110) -> out_valid and alu_opcode stay stable; then out_ready=1 with in_valid add -> 0010 next cycle, no bubble.
REQ-033 flush at cycle 2 of div (1000) -> IDLE at cycle 3, no out_valid, busy 0; reset_n low mid-MULTI -> all outputs reset values.
REQ-034 funct 111111 with ALU_CTRL_ILLEGAL_TRAP_EN -> alu_opcode 1111, illegal 1 until flush; without macro -> 0010, illegal 0.
